// File: rtl/mvp_acc_if.sv
// Stream bundle for mvp_acc: bit-plane partial-sum input beats and lane-result output.
interface mvp_acc_if #(
   parameter int N  = 64,
   parameter int OW = 32
);
   localparam int AW = $clog2(N) + 2;

   logic            s_valid;
   logic            s_ready;
   logic [N*AW-1:0] s_data;
   logic            s_first;
   logic            s_last;
   logic            s_neg;
   logic            r_valid;
   logic            r_ready;
   logic [N*OW-1:0] r_data;
   logic            r_ovf;

   modport master (
      output s_valid, s_data, s_first, s_last, s_neg, r_ready,
      input  s_ready, r_valid, r_data, r_ovf
   );

   modport slave (
      input  s_valid, s_data, s_first, s_last, s_neg, r_ready,
      output s_ready, r_valid, r_data, r_ovf
   );
endinterface

// File: rtl/mvp_acc.sv
// Bit-serial accumulator: shifts and adds signed per-lane partial sums, one bit-plane per beat,
// MSB plane first, and emits the N lane results with a sticky overflow flag.
module mvp_acc #(
   parameter int N  = 64,
   parameter int OW = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   mvp_acc_if.slave bus,
   output logic     s_err,
   output logic     busy
);
   localparam int A  = $clog2(N);
   localparam int AW = A + 2;

   typedef enum logic {IDLE, ACC} state_t;

   state_t              state, state_nx;
   logic                accept, restart, accum, emit, err_nx, update;
   logic signed [OW-1:0] acc    [N];
   logic signed [OW-1:0] acc_nx [N];
   logic [N-1:0]        lane_ovf;
   logic                ovf, ovf_nx;

   assign bus.s_ready = !bus.r_valid || bus.r_ready;
   assign accept      = bus.s_valid && bus.s_ready;
   assign busy        = (state == ACC);
   assign update      = restart || accum;

   always_comb begin
      state_nx = state;
      restart  = 1'b0;
      accum    = 1'b0;
      emit     = 1'b0;
      err_nx   = 1'b0;
      if (accept) begin
         if (bus.s_first) begin
            restart = 1'b1;
            err_nx  = (state == ACC);
            if (bus.s_last) begin
               emit     = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = ACC;
            end
         end else if (state == ACC) begin
            accum = 1'b1;
            if (bus.s_last) begin
               emit     = 1'b1;
               state_nx = IDLE;
            end
         end else begin
            err_nx = 1'b1;
         end
      end
   end

   // Two guard bits hold the exact 2*acc+p; once the exact value leaves range it can
   // never re-enter, so checking the wrapped acc each beat is enough for the sticky flag.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic signed [AW-1:0]   lane;
      logic signed [OW+1:0]   p, base, ex;
      assign lane         = bus.s_data[g*AW +: AW];
      assign p            = bus.s_neg ? -((OW+2)'(lane)) : (OW+2)'(lane);
      assign base         = restart ? '0 : {acc[g][OW-1], acc[g], 1'b0};
      assign ex           = base + p;
      assign acc_nx[g]    = ex[OW-1:0];
      assign lane_ovf[g]  = (ex[OW+1:OW-1] != '0) && (ex[OW+1:OW-1] != '1);
   end

   assign ovf_nx = (restart ? 1'b0 : ovf) || (|lane_ovf);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ovf         <= 1'b0;
         s_err       <= 1'b0;
         bus.r_valid <= 1'b0;
         bus.r_ovf   <= 1'b0;
         bus.r_data  <= '0;
         for (int unsigned i = 0; i < N; i++) acc[i] <= '0;
      end else begin
         state <= state_nx;
         s_err <= err_nx;
         if (update) begin
            ovf <= ovf_nx;
            for (int unsigned i = 0; i < N; i++) acc[i] <= acc_nx[i];
         end
         if (emit) begin
            bus.r_valid <= 1'b1;
            bus.r_ovf   <= ovf_nx;
            for (int unsigned i = 0; i < N; i++) bus.r_data[i*OW +: OW] <= acc_nx[i];
         end else if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mvp_acc.sv
// Directed bench for mvp_acc (N=4, OW=8): exact-integer lane model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_mvp_acc;
   localparam int N  = 4;
   localparam int OW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic s_err, busy;
   int   total = 0;
   int   bad   = 0;

   mvp_acc_if #(.N(N), .OW(OW)) bus ();
   mvp_acc #(.N(N), .OW(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .s_err(s_err), .busy(busy));

   always #5 clk = ~clk;

   // Model state: exact unbounded lane values, operation-open flag, pending result.
   longint          m_ex [N] = '{default: 0};
   logic            m_busy  = 1'b0;
   logic            m_ovf   = 1'b0;
   logic            m_rv    = 1'b0;
   logic            m_rovf  = 1'b0;
   logic            m_err   = 1'b0;
   logic [N*OW-1:0] m_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) m_ex[i] = 0;
         m_busy = 0; m_ovf = 0; m_rv = 0; m_rovf = 0; m_err = 0; m_rdata = '0;
      end else begin
         logic take, fire, err;
         take = bus.s_valid && (!m_rv || bus.r_ready);
         fire = 0;
         err  = 0;
         if (take && (bus.s_first || m_busy)) begin
            if (bus.s_first) begin
               err   = m_busy;
               m_ovf = 0;
            end
            for (int i = 0; i < N; i++) begin
               logic signed [AW-1:0] lv;
               longint p;
               lv = bus.s_data[i*AW +: AW];
               p  = bus.s_neg ? -longint'(lv) : longint'(lv);
               m_ex[i] = (bus.s_first ? 0 : 2 * m_ex[i]) + p;
               if (m_ex[i] > 127 || m_ex[i] < -128) m_ovf = 1;
            end
            fire   = bus.s_last;
            m_busy = !bus.s_last;
         end else if (take) begin
            err = 1;
         end
         if (fire) begin
            m_rv   = 1;
            m_rovf = m_ovf;
            for (int i = 0; i < N; i++) begin
               longint e;
               e = m_ex[i];
               m_rdata[i*OW +: OW] = e[7:0];
            end
         end else if (bus.r_ready) begin
            m_rv = 0;
         end
         m_err = err;
      end
   end

   always @(negedge clk) begin
      chk("s_ready", {31'b0, bus.s_ready}, {31'b0, !m_rv || bus.r_ready});
      chk("r_valid", {31'b0, bus.r_valid}, {31'b0, m_rv});
      chk("busy",    {31'b0, busy},        {31'b0, m_busy});
      chk("s_err",   {31'b0, s_err},       {31'b0, m_err});
      if (m_rv || !rst_n) begin
         chk("r_data", bus.r_data, m_rdata);
         chk("r_ovf",  {31'b0, bus.r_ovf}, {31'b0, m_rovf});
      end
   end

   function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
      logic [3:0] la, lb, lc, ld;
      la = 4'(a); lb = 4'(b); lc = 4'(c); ld = 4'(d);
      return {ld, lc, lb, la};
   endfunction

   task automatic beat(input logic [15:0] d, input logic f, input logic l, input logic n);
      int unsigned k = 0;
      @(negedge clk); #1;
      bus.s_valid = 1; bus.s_data = d; bus.s_first = f; bus.s_last = l; bus.s_neg = n;
      while (!bus.s_ready && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      chk("beat_accept", {31'b0, bus.s_ready}, 32'd1);
      @(posedge clk); #1;
      bus.s_valid = 0; bus.s_first = 0; bus.s_last = 0; bus.s_neg = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      bus.s_valid = 0; bus.s_data = '0; bus.s_first = 0; bus.s_last = 0; bus.s_neg = 0;
      bus.r_ready = 1;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", {31'b0, bus.s_ready}, 32'd1);
      chk("rst_r_data", bus.r_data, 32'h0);
      #2 rst_n = 1;

      // Sign plane then one more plane: 2*(-3)+1 = -5
      beat(pk(3, 3, 3, 3), 1, 0, 1);
      beat(pk(1, 1, 1, 1), 0, 1, 0);
      @(negedge clk);
      chk("neg_r_valid", {31'b0, bus.r_valid}, 32'd1);
      chk("neg_r_data", bus.r_data, 32'hFBFBFBFB);
      chk("neg_model", m_rdata, 32'hFBFBFBFB);

      // Mixed lanes: {2-(-1), -4-3, 14-0, -16-2}
      beat(pk(1, -2, 7, -8), 1, 0, 0);
      beat(pk(-1, 3, 0, 2), 0, 1, 1);
      @(negedge clk);
      chk("mix_r_data", bus.r_data, 32'hEE0EF903);
      chk("mix_model", m_rdata, 32'hEE0EF903);

      // Single-plane negate of the most negative lane value
      beat(pk(-8, -8, -8, -8), 1, 1, 1);
      @(negedge clk);
      chk("one_r_data", bus.r_data, 32'h08080808);
      chk("one_busy", {31'b0, busy}, 32'd0);

      // Eight planes of +4 overflow 8 bits; next operation clears the flag
      for (int b = 0; b < 8; b++) beat(pk(4, 4, 4, 4), b == 0, b == 7, 0);
      @(negedge clk);
      chk("ovf_r_data", bus.r_data, 32'hFCFCFCFC);
      chk("ovf_r_ovf", {31'b0, bus.r_ovf}, 32'd1);
      chk("ovf_model", {31'b0, m_rovf}, 32'd1);
      beat(pk(1, 1, 1, 1), 1, 1, 0);
      @(negedge clk);
      chk("clr_r_data", bus.r_data, 32'h01010101);
      chk("clr_r_ovf", {31'b0, bus.r_ovf}, 32'd0);

      // Backpressure
      @(posedge clk); #1;
      bus.r_ready = 0;
      beat(pk(2, 2, 2, 2), 1, 1, 0);
      bus.s_valid = 1; bus.s_data = pk(5, 5, 5, 5); bus.s_first = 1; bus.s_last = 1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_s_ready", {31'b0, bus.s_ready}, 32'd0);
         chk("bp_r_data", bus.r_data, 32'h02020202);
      end
      #1 bus.r_ready = 1;
      @(posedge clk); #1;
      bus.s_valid = 0; bus.s_first = 0; bus.s_last = 0;
      @(negedge clk);
      chk("bp_r_valid", {31'b0, bus.r_valid}, 32'd1);
      chk("bp_new_data", bus.r_data, 32'h05050505);

      // Protocol violations
      beat(pk(7, 7, 7, 7), 0, 1, 0);
      @(negedge clk);
      chk("idle_err", {31'b0, s_err}, 32'd1);
      @(negedge clk);
      chk("idle_err_end", {31'b0, s_err}, 32'd0);
      beat(pk(1, 1, 1, 1), 1, 0, 0);
      beat(pk(2, 2, 2, 2), 1, 0, 0);
      @(negedge clk);
      chk("acc_err", {31'b0, s_err}, 32'd1);
      beat(pk(1, 1, 1, 1), 0, 1, 0);
      @(negedge clk);
      chk("restart_r_data", bus.r_data, 32'h05050505);

      // Asynchronous reset mid-operation
      beat(pk(1, 1, 1, 1), 1, 0, 0);
      #1 rst_n = 0;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_r_valid", {31'b0, bus.r_valid}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1;
      beat(pk(3, 3, 3, 3), 0, 1, 0);
      @(negedge clk);
      chk("arst_err", {31'b0, s_err}, 32'd1);
      chk("arst_no_result", {31'b0, bus.r_valid}, 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
